dmem_arbiter: RTL and testbench

Two-requester arbiter in front of the 256x8 data memory, sharing its independent read and write ports between the CPU load/store unit and the DMA engine. Each clock cycle it grants at most one read and at most one write, possibly to different requesters. CPU has fixed priority on each port, with a starvation guard for DMA. Read data is returned one cycle after acceptance.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arbiter_if.sv | 27 ++
 rtl/dmem_arbiter_slot_arbiter.sv | 59 +++++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and widths for the data-memory arbiter.
//   req_e    : requester identity, also the bit index of a one-hot grant.
//   ADDR_W   : memory address width (256-entry memory).
//   DATA_W   : memory data width.
//   STARVE_W : width of each per-slot starvation counter.
package dmem_arb_pkg;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int STARVE_W = 4;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's request/response channel to the arbiter.
//   req_valid/req_we/req_addr/req_wdata : request, held stable until accepted
//   req_ready                            : request accepted this cycle
//   rsp_valid/rsp_data                   : read data, one cycle after acceptance
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if;
    import dmem_arb_pkg::*;

    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/dmem_arbiter_slot_arbiter.sv
// slot_arbiter: two-input fixed-priority arbiter (CPU over DMA) for one
// memory port, with a starvation counter that hands DMA the slot once it
// has lost STARVE_LIMIT consecutive contentions.
//   clk, reset  : clock, synchronous active-high reset
//   cpu_want_i  : CPU wants this slot
//   dma_want_i  : DMA wants this slot
//   grant_o     : one-hot grant indexed by req_e (all zero during reset)
module slot_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_want_i,
    input  logic       dma_want_i,
    output logic [1:0] grant_o
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                contend;

    always_comb begin
        grant_o  = '0;
        starve_d = '0;
        contend  = cpu_want_i & dma_want_i;

        if (!reset) begin
            if (contend) begin
                if (starve_q == LIMIT) begin
                    grant_o[REQ_DMA] = 1'b1;
                end else begin
                    grant_o[REQ_CPU] = 1'b1;
                end
            end else if (cpu_want_i) begin
                grant_o[REQ_CPU] = 1'b1;
            end else if (dma_want_i) begin
                grant_o[REQ_DMA] = 1'b1;
            end
        end

        // Only a lost contention keeps the count alive; any DMA grant or
        // DMA absence restarts it from zero.
        if (contend && grant_o[REQ_CPU]) begin
            starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the independent read and write ports of a 256x8
// data memory between the CPU load/store unit and the DMA engine. Each
// cycle at most one read and one write are granted, each slot arbitrated
// separately. Read data returns one cycle after acceptance.
//   clk, reset        : clock, synchronous active-high reset
//   cpu, dma          : requester channels (dmem_arbiter_if.slave)
//   mem_read_address  : memory read address (holds last granted address)
//   mem_data_out      : combinational read data from memory
//   mem_write         : memory write enable (forced low during reset)
//   mem_write_address : memory write address (holds last granted address)
//   mem_data_in       : memory write data (holds last granted data)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     cpu,
    dmem_arbiter_if.slave     dma,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_data_in
);

    logic [1:0] rd_grant, wr_grant;

    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              cpu_rsp_valid_q, dma_rsp_valid_q;
    logic [DATA_W-1:0] cpu_rsp_data_q, cpu_rsp_data_d;
    logic [DATA_W-1:0] dma_rsp_data_q, dma_rsp_data_d;

    slot_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_rd_slot (
        .clk        (clk),
        .reset      (reset),
        .cpu_want_i (cpu.req_valid & ~cpu.req_we),
        .dma_want_i (dma.req_valid & ~dma.req_we),
        .grant_o    (rd_grant)
    );

    slot_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_wr_slot (
        .clk        (clk),
        .reset      (reset),
        .cpu_want_i (cpu.req_valid & cpu.req_we),
        .dma_want_i (dma.req_valid & dma.req_we),
        .grant_o    (wr_grant)
    );

    assign cpu.req_ready = rd_grant[REQ_CPU] | wr_grant[REQ_CPU];
    assign dma.req_ready = rd_grant[REQ_DMA] | wr_grant[REQ_DMA];

    always_comb begin
        rd_addr_d      = rd_addr_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        cpu_rsp_data_d = cpu_rsp_data_q;
        dma_rsp_data_d = dma_rsp_data_q;

        if (rd_grant[REQ_CPU]) begin
            rd_addr_d      = cpu.req_addr;
            cpu_rsp_data_d = mem_data_out;
        end else if (rd_grant[REQ_DMA]) begin
            rd_addr_d      = dma.req_addr;
            dma_rsp_data_d = mem_data_out;
        end

        if (wr_grant[REQ_CPU]) begin
            wr_addr_d = cpu.req_addr;
            wr_data_d = cpu.req_wdata;
        end else if (wr_grant[REQ_DMA]) begin
            wr_addr_d = dma.req_addr;
            wr_data_d = dma.req_wdata;
        end
    end

    // Memory drive: the granted request passes straight through; when a
    // slot is idle its last granted values are held. Reset forces zero
    // without waiting for the registers to clear.
    assign mem_read_address  = reset ? '0 : rd_addr_d;
    assign mem_write_address = reset ? '0 : wr_addr_d;
    assign mem_data_in       = reset ? '0 : wr_data_d;
    assign mem_write         = ~reset & (|wr_grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_q       <= '0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            cpu_rsp_valid_q <= 1'b0;
            dma_rsp_valid_q <= 1'b0;
            cpu_rsp_data_q  <= '0;
            dma_rsp_data_q  <= '0;
        end else begin
            rd_addr_q       <= rd_addr_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            cpu_rsp_valid_q <= rd_grant[REQ_CPU];
            dma_rsp_valid_q <= rd_grant[REQ_DMA];
            cpu_rsp_data_q  <= cpu_rsp_data_d;
            dma_rsp_data_q  <= dma_rsp_data_d;
        end
    end

    assign cpu.rsp_valid = cpu_rsp_valid_q;
    assign cpu.rsp_data  = cpu_rsp_data_q;
    assign dma.rsp_valid = dma_rsp_valid_q;
    assign dma.rsp_data  = dma_rsp_data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. A bench-side
// 256x8 memory serves the DUT; a behavioural model tracks arbitration,
// memory contents and responses and is compared every cycle.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int LIM = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if cpu_if ();
    dmem_arbiter_if dma_if ();

    logic [7:0] mem_read_address, mem_data_out, mem_write_address, mem_data_in;
    logic       mem_write;

    dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk               (clk),
        .reset             (reset),
        .cpu               (cpu_if),
        .dma               (dma_if),
        .mem_read_address  (mem_read_address),
        .mem_data_out      (mem_data_out),
        .mem_write         (mem_write),
        .mem_write_address (mem_write_address),
        .mem_data_in       (mem_data_in)
    );

    // Memory seen by the DUT: preloaded on the first edge, then written by the DUT.
    logic [7:0] mem [256];
    bit         mem_loaded = 1'b0;
    assign mem_data_out = mem[mem_read_address];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 8'h5A : 8'h00;
            mem_loaded <= 1'b1;
        end else if (mem_write === 1'b1) begin
            mem[mem_write_address] <= mem_data_in;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_cnt [2];       // lost-contention count: [0]=read slot, [1]=write slot
    logic [7:0] ref_mem [256];
    logic       e_rv [2];        // expected rsp_valid this cycle: [0]=cpu, [1]=dma
    logic [7:0] e_rd [2];
    logic [7:0] e_ra, e_wa, e_wd;
    bit         m_known = 1'b0;

    // Winner of one slot: 0 = CPU, 1 = DMA, -1 = nobody.
    function automatic int pick(input bit cw, input bit dw, input int cnt);
        if (cw && dw) return (cnt == LIM) ? 1 : 0;
        if (cw) return 0;
        if (dw) return 1;
        return -1;
    endfunction

    function automatic int next_cnt(input bit cw, input bit dw, input int win, input int cnt);
        if (cw && dw && win == 0) return (cnt + 1 > LIM) ? LIM : cnt + 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        bit         v [2];
        bit         we [2];
        logic [7:0] a [2];
        logic [7:0] d [2];
        int         rw, ww;
        v[0] = cpu_if.req_valid; we[0] = cpu_if.req_we; a[0] = cpu_if.req_addr; d[0] = cpu_if.req_wdata;
        v[1] = dma_if.req_valid; we[1] = dma_if.req_we; a[1] = dma_if.req_addr; d[1] = dma_if.req_wdata;

        if (reset) begin
            chk("rst_cpu_ready", cpu_if.req_ready, 0);
            chk("rst_dma_ready", dma_if.req_ready, 0);
            chk("rst_mem_write", mem_write, 0);
            chk("rst_rd_addr", mem_read_address, 0);
            chk("rst_wr_addr", mem_write_address, 0);
            chk("rst_wr_data", mem_data_in, 0);
            if (m_known) begin
                chk("rst_cpu_rsp_valid", cpu_if.rsp_valid, e_rv[0]);
                chk("rst_dma_rsp_valid", dma_if.rsp_valid, e_rv[1]);
                chk("rst_cpu_rsp_data", cpu_if.rsp_data, e_rd[0]);
                chk("rst_dma_rsp_data", dma_if.rsp_data, e_rd[1]);
            end else begin
                for (int i = 0; i < 256; i++) ref_mem[i] = (i == 16) ? 8'h5A : 8'h00;
            end
            m_known  = 1'b1;
            m_cnt[0] = 0; m_cnt[1] = 0;
            e_rv[0]  = 1'b0; e_rv[1] = 1'b0;
            e_rd[0]  = 8'h00; e_rd[1] = 8'h00;
            e_ra = 8'h00; e_wa = 8'h00; e_wd = 8'h00;
        end else if (m_known) begin
            rw = pick(v[0] && !we[0], v[1] && !we[1], m_cnt[0]);
            ww = pick(v[0] && we[0], v[1] && we[1], m_cnt[1]);
            if (rw >= 0) e_ra = a[rw];
            if (ww >= 0) begin
                e_wa = a[ww];
                e_wd = d[ww];
            end
            chk("cpu_ready", cpu_if.req_ready, (rw == 0) || (ww == 0));
            chk("dma_ready", dma_if.req_ready, (rw == 1) || (ww == 1));
            chk("mem_read_address", mem_read_address, e_ra);
            chk("mem_write", mem_write, ww >= 0);
            chk("mem_write_address", mem_write_address, e_wa);
            chk("mem_data_in", mem_data_in, e_wd);
            chk("cpu_rsp_valid", cpu_if.rsp_valid, e_rv[0]);
            chk("dma_rsp_valid", dma_if.rsp_valid, e_rv[1]);
            chk("cpu_rsp_data", cpu_if.rsp_data, e_rd[0]);
            chk("dma_rsp_data", dma_if.rsp_data, e_rd[1]);

            m_cnt[0] = next_cnt(v[0] && !we[0], v[1] && !we[1], rw, m_cnt[0]);
            m_cnt[1] = next_cnt(v[0] && we[0], v[1] && we[1], ww, m_cnt[1]);
            for (int r = 0; r < 2; r++) begin
                e_rv[r] = (rw == r);
                if (rw == r) e_rd[r] = ref_mem[a[r]];
            end
            if (ww >= 0) ref_mem[e_wa] = e_wd;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
        cpu_if.req_valid = v; cpu_if.req_we = we; cpu_if.req_addr = a; cpu_if.req_wdata = d;
    endtask

    task automatic set_dma(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
        dma_if.req_valid = v; dma_if.req_we = we; dma_if.req_addr = a; dma_if.req_wdata = d;
    endtask

    initial begin
        logic [11:0] pat12, cpat12;
        logic [4:0]  pat5;
        bit          acc_c, acc_d;

        set_cpu(0, 0, 8'h00, 8'h00);
        set_dma(0, 0, 8'h00, 8'h00);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // CPU read only
        set_cpu(1, 0, 8'h10, 8'h00);
        @(negedge clk);
        chk("t1_cpu_ready", cpu_if.req_ready, 1);
        step();
        set_cpu(0, 0, 8'h00, 8'h00);
        @(negedge clk);
        chk("t1_cpu_rsp_valid", cpu_if.rsp_valid, 1);
        chk("t1_cpu_rsp_data", cpu_if.rsp_data, 8'h5A);
        chk("t1_dma_rsp_valid", dma_if.rsp_valid, 0);
        step();

        // Parallel slots, same address: read sees the pre-write value
        set_cpu(1, 1, 8'h20, 8'h33);
        set_dma(1, 0, 8'h20, 8'h00);
        @(negedge clk);
        chk("t2_cpu_ready", cpu_if.req_ready, 1);
        chk("t2_dma_ready", dma_if.req_ready, 1);
        chk("t2_mem_write", mem_write, 1);
        step();
        set_cpu(0, 0, 8'h00, 8'h00);
        @(negedge clk);
        chk("t2_dma_old_valid", dma_if.rsp_valid, 1);
        chk("t2_dma_old_data", dma_if.rsp_data, 8'h00);
        step();
        set_dma(0, 0, 8'h00, 8'h00);
        @(negedge clk);
        chk("t2_dma_new_data", dma_if.rsp_data, 8'h33);
        step();

        // Read contention: CPU x4, DMA, repeat
        set_cpu(1, 0, 8'h01, 8'h00);
        set_dma(1, 0, 8'h02, 8'h00);
        pat12 = '0; cpat12 = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pat12  = {pat12[10:0], dma_if.req_ready};
            cpat12 = {cpat12[10:0], cpu_if.req_ready};
            step();
        end
        chk("t3_dma_grant_pattern", pat12, 12'b0000_1000_0100);
        chk("t3_cpu_grant_pattern", cpat12, 12'b1111_0111_1011);

        // Counter clear: idle, 2 losses, idle, then 4 losses before a grant
        set_dma(0, 0, 8'h02, 8'h00);
        step();
        set_dma(1, 0, 8'h02, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t4_dma_loses", dma_if.req_ready, 0);
            step();
        end
        set_dma(0, 0, 8'h02, 8'h00);
        step();
        set_dma(1, 0, 8'h02, 8'h00);
        pat5 = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pat5 = {pat5[3:0], dma_if.req_ready};
            step();
        end
        chk("t4_dma_grant_pattern", pat5, 5'b00001);

        // Reset while both issue writes
        set_cpu(1, 1, 8'h40, 8'h11);
        set_dma(1, 1, 8'h41, 8'h22);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_mem_write", mem_write, 0);
        step();
        @(negedge clk);
        chk("t5_cpu_ready", cpu_if.req_ready, 0);
        chk("t5_dma_ready", dma_if.req_ready, 0);
        chk("t5_cpu_rsp_valid", cpu_if.rsp_valid, 0);
        chk("t5_dma_rsp_valid", dma_if.rsp_valid, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_first_cpu_write", cpu_if.req_ready, 1);
        chk("t5_first_write_addr", mem_write_address, 8'h40);
        step();
        set_cpu(0, 0, 8'h00, 8'h00);
        step();
        set_dma(0, 0, 8'h00, 8'h00);

        // Reset right after a read acceptance
        set_cpu(1, 0, 8'h10, 8'h00);
        step();
        set_cpu(0, 0, 8'h00, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rsp_valid_before", cpu_if.rsp_valid, 1);
        chk("t6_rsp_data_before", cpu_if.rsp_data, 8'h5A);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rsp_valid_after", cpu_if.rsp_valid, 0);
        chk("t6_rsp_data_after", cpu_if.rsp_data, 8'h00);
        step();

        // Randomized traffic with occasional reset pulses
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc_c = cpu_if.req_valid && cpu_if.req_ready;
            acc_d = dma_if.req_valid && dma_if.req_ready;
            step();
            reset = ($urandom_range(0, 199) == 0);
            if (acc_c) cpu_if.req_valid = 1'b0;
            if (acc_d) dma_if.req_valid = 1'b0;
            if (!cpu_if.req_valid && $urandom_range(0, 9) < 7)
                set_cpu(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
            if (!dma_if.req_valid && $urandom_range(0, 9) < 8)
                set_dma(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
        end
        reset = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
